alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked ALU. Same 8-op set as the combinational ALU, with these additions:
//  WIDTH-generic operands, valid/ready flow control on both sides, and zero/carry flags.
//  ADD/SUB/INC/logic results take one cycle. MUL is a sequential shift-add unit that takes
//  WIDTH cycles. Sits between an operand producer and a result consumer on one clock domain.
// PARAMETERS
//  WIDTH  8  operand width in bits (>=2); F is 2*WIDTH bits wide
// PORTS
//  clk        in   1        clock; all state updates on rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        producer presents A/B/Sel
//  in_ready   out  1        ALU can accept an operation this cycle
//  A          in   WIDTH    operand A (unsigned)
//  B          in   WIDTH    operand B (unsigned)
//  Sel        in   3        0 ADD, 1 SUB, 2 MUL, 3 INC A, 4 AND, 5 OR, 6 XNOR, 7 XOR
//  out_valid  out  1        F/zero/carry hold a result
//  out_ready  in   1        consumer accepts the result
//  F          out  2*WIDTH  result, zero-extended
//  zero       out  1        F == 0
//  carry      out  1        ADD/INC carry-out; SUB borrow (A<B); 0 for all other ops
//  busy       out  1        high in MUL state
// BEHAVIOUR
//  - One clock (clk). Synchronous active-high reset (rst), sampled on the rising edge.
//  - Reset (also mid-operation): state<=IDLE; out_valid, F, zero, carry, busy <= 0.
//    Any operation in progress is discarded. in_ready=0 while rst=1.
//  - FSM states: IDLE, MUL, DONE. in_ready = (state==IDLE) && !rst. No overlap of operations.
//  - Accept: an operation is accepted on the edge where in_valid && in_ready.
//    A, B and Sel are registered on that edge. Later input changes are ignored.
//  - Non-MUL op accepted on edge k: the result, zero and carry are registered on edge k, and
//    state goes to DONE. out_valid=1 from the cycle after edge k (latency 1).
//  - MUL accepted on edge k: state goes to MUL and busy=1. The multiplicand, multiplier,
//    accumulator=0 and counter=0 are loaded.
//    Edges k+1 .. k+WIDTH each do one iteration:
//      if mult[0], acc += mcand<<i; then mult>>=1.
//    On edge k+WIDTH: F=acc, state goes to DONE, busy=0. out_valid=1 from the next cycle.
//    Latency is WIDTH+1 edges. No overflow is possible, because the product fits in 2*WIDTH.
//  - Width rules:
//    ADD  {A+B} WIDTH+1 bits, carry = bit WIDTH.
//    SUB  (A-B) mod 2^(WIDTH+1), so bit WIDTH = borrow = carry.
//    INC  A+1, WIDTH+1 bits, carry = bit WIDTH.
//    Logic ops: WIDTH bits.
//    Every result is zero-extended to 2*WIDTH. zero is computed on the final F.
//  - DONE: F/zero/carry/out_valid are held stable while out_ready=0.
//    On the edge where out_valid && out_ready: out_valid<=0, state<=IDLE. F keeps its last value.
//    in_ready rises in the following cycle, so there is one bubble between operations.
//  - in_valid while not in_ready: ignored, not queued.
//  - rst on the same edge as accept or output transfer: reset wins.
// TESTING (WIDTH=8)
//  - ADD A=200,B=100, out_ready=1 -> out_valid 1 cycle after accept; F=0x012C, carry=1, zero=0.
//  - SUB A=5,B=7 -> F=0x01FE, carry=1. SUB A=7,B=7 -> F=0x0000, zero=1, carry=0.
//  - MUL A=255,B=255 -> busy=1 for 8 cycles; out_valid 9 edges after accept; F=0xFE01.
//  - Backpressure: INC A=0xFF with out_ready=0 for 5 cycles ->
//    F=0x0100, carry=1 stable; in_ready=0; a second in_valid is ignored.
//    After out_ready=1: out_valid drops, then in_ready=1.
//  - Reset mid-MUL: assert rst on the 3rd MUL edge -> next cycle out_valid=0, busy=0, F=0.
//    in_ready=1 after rst deasserts; a following AND 0xF0,0x3C gives F=0x0030.
//  - Logic sweep: Sel 4..7 with A=0xF0,B=0x0F -> F=0x0000 (zero=1), 0x00FF, 0x0000, 0x00FF.
//    carry=0 in all four cases.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked ALU with zero/carry flags. Single-cycle ADD/SUB/INC/logic ops and a
// shift-add multiplier that iterates once per clock for WIDTH clocks.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for an operation; in_ready high unless in reset
//   MUL    | shift-add multiply in progress; busy high
//   DONE   | F/zero/carry valid and held until the consumer takes them
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         Sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] F,
  output logic               zero,
  output logic               carry,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic               accept;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mult;
  logic [CW-1:0]      cnt;
  logic               last_iter;
  logic [WIDTH:0]     ext;
  logic [2*WIDTH-1:0] res;
  logic               res_carry;

  // in_ready already excludes reset, so a reset edge can never also accept
  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt == CW'(WIDTH - 1));
  // mcand is pre-shifted each iteration, so adding it equals adding A << i
  assign acc_nxt   = mult[0] ? (acc + mcand) : acc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (Sel == OP_MUL) ? S_MUL : S_DONE;
        end
      end
      S_MUL: begin
        if (last_iter) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE:  in_ready  = !rst;
      S_MUL:   busy      = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Single-cycle result; arithmetic ops carry out in bit WIDTH of ext
  always_comb begin
    ext       = '0;
    res       = '0;
    res_carry = 1'b0;
    case (Sel)
      OP_ADD: begin
        ext       = {1'b0, A} + {1'b0, B};
        res       = {{(WIDTH-1){1'b0}}, ext};
        res_carry = ext[WIDTH];
      end
      OP_SUB: begin
        ext       = {1'b0, A} - {1'b0, B};
        res       = {{(WIDTH-1){1'b0}}, ext};
        res_carry = ext[WIDTH];
      end
      OP_INC: begin
        ext       = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};
        res       = {{(WIDTH-1){1'b0}}, ext};
        res_carry = ext[WIDTH];
      end
      OP_AND:  res = {{WIDTH{1'b0}}, A & B};
      OP_OR:   res = {{WIDTH{1'b0}}, A | B};
      OP_XNOR: res = {{WIDTH{1'b0}}, ~(A ^ B)};
      OP_XOR:  res = {{WIDTH{1'b0}}, A ^ B};
      default: ;
    endcase
  end

  // Operand capture, multiply iterations and result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      F     <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
      mcand <= '0;
      mult  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      if (accept) begin
        if (Sel == OP_MUL) begin
          mcand <= {{WIDTH{1'b0}}, A};
          mult  <= B;
          acc   <= '0;
          cnt   <= '0;
        end else begin
          F     <= res;
          zero  <= (res == '0);
          carry <= res_carry;
        end
      end
      if (state == S_MUL) begin
        acc   <= acc_nxt;
        mcand <= mcand << 1;
        mult  <= mult >> 1;
        cnt   <= cnt + CW'(1);
        if (last_iter) begin
          F     <= acc_nxt;
          zero  <= (acc_nxt == '0);
          carry <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed vector table, hand-written
// backpressure/reset sequences, and randomized ops against an arithmetic model.
module tb_alu_seq;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [2:0]     Sel;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] F;
  logic           zero;
  logic           carry;
  logic           busy;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic [2:0]  sel;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] f;
    logic        z;
    logic        c;
  } vec_t;

  vec_t vecs[12];

  // Free-running clock
  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Sel       (Sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .F         (F),
    .zero      (zero),
    .carry     (carry),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the op definitions
  function automatic void model(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                                output logic [15:0] f, output logic c);
    int ia;
    int ib;
    int r;
    ia = int'(a);
    ib = int'(b);
    r  = 0;
    c  = 1'b0;
    case (sel)
      3'd0: begin r = ia + ib; c = (r > 255); end
      3'd1: begin r = (ia - ib + 512) % 512; c = (ia < ib); end
      3'd2: r = ia * ib;
      3'd3: begin r = ia + 1; c = (r > 255); end
      3'd4: r = ia & ib;
      3'd5: r = ia | ib;
      3'd6: r = (~(ia ^ ib)) & 255;
      default: r = ia ^ ib;
    endcase
    f = 16'(r);
  endfunction

  // Issue one op at the current negedge, wait for result, stall the consumer, check bubble
  task automatic run_op(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                        input int stall, output logic [15:0] f, output logic z,
                        output logic c, output int lat, output int nbusy);
    logic [15:0] ef;
    logic        ec;
    model(sel, a, b, ef, ec);
    Sel       = sel;
    A         = a;
    B         = b;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    #1;
    chk("in_ready_issue", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    A        = 8'($urandom);
    B        = 8'($urandom);
    Sel      = 3'($urandom);
    lat      = 1;
    nbusy    = 0;
    while (!out_valid && lat < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    chk("out_valid_seen", out_valid, 1);
    f = F;
    z = zero;
    c = carry;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_F", F, ef);
      chk("hold_carry", carry, ec);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bubble_valid", out_valid, 0);
    chk("bubble_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [15:0] f;
    logic        z;
    logic        c;
    logic [15:0] ef;
    logic        ec;
    logic [2:0]  rs;
    logic [7:0]  ra;
    logic [7:0]  rb;
    int          lat;
    int          nb;

    vecs[0]  = '{3'd0, 8'd200, 8'd100, 16'h012C, 1'b0, 1'b1};
    vecs[1]  = '{3'd1, 8'd5,   8'd7,   16'h01FE, 1'b0, 1'b1};
    vecs[2]  = '{3'd1, 8'd7,   8'd7,   16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{3'd2, 8'hFF,  8'hFF,  16'hFE01, 1'b0, 1'b0};
    vecs[4]  = '{3'd3, 8'hFF,  8'h00,  16'h0100, 1'b0, 1'b1};
    vecs[5]  = '{3'd4, 8'hF0,  8'h0F,  16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{3'd5, 8'hF0,  8'h0F,  16'h00FF, 1'b0, 1'b0};
    vecs[7]  = '{3'd6, 8'hF0,  8'h0F,  16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{3'd7, 8'hF0,  8'h0F,  16'h00FF, 1'b0, 1'b0};
    vecs[9]  = '{3'd2, 8'h00,  8'h5A,  16'h0000, 1'b1, 1'b0};
    vecs[10] = '{3'd2, 8'd13,  8'd11,  16'd143,  1'b0, 1'b0};
    vecs[11] = '{3'd3, 8'h12,  8'h00,  16'h0013, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    Sel       = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_F", F, 0);
    chk("rst_zero", zero, 0);
    chk("rst_carry", carry, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, 0, f, z, c, lat, nb);
      chk($sformatf("vec%0d_F", i), f, vecs[i].f);
      chk($sformatf("vec%0d_zero", i), z, vecs[i].z);
      chk($sformatf("vec%0d_carry", i), c, vecs[i].c);
      chk($sformatf("vec%0d_latency", i), lat, (vecs[i].sel == 3'd2) ? 9 : 1);
      chk($sformatf("vec%0d_busy_cycles", i), nb, (vecs[i].sel == 3'd2) ? 8 : 0);
    end

    // Backpressure: INC 0xFF held for 5 stalled cycles, second request ignored
    Sel       = 3'd3;
    A         = 8'hFF;
    B         = 8'h00;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_latency", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_F", F, 16'h0100);
      chk("bp_carry", carry, 1);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      if (i == 1) begin
        in_valid = 1'b1;
        Sel      = 3'd0;
        A        = 8'd1;
        B        = 8'd1;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_F_last", F, 16'h0100);
    @(negedge clk);
    chk("bp_drop_valid", out_valid, 0);
    chk("bp_in_ready_up", in_ready, 1);
    chk("bp_F_kept", F, 16'h0100);
    @(negedge clk);
    chk("bp_not_queued", out_valid, 0);

    // Reset on the 3rd multiply iteration edge
    Sel      = 3'd2;
    A        = 8'hFF;
    B        = 8'hFF;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rm_busy", busy, 1);
    @(negedge clk);
    @(negedge clk);
    chk("rm_F_before", F, 16'h0100);
    rst = 1'b1;
    #1;
    chk("rm_in_ready_rst", in_ready, 0);
    @(negedge clk);
    chk("rm_out_valid", out_valid, 0);
    chk("rm_busy_clr", busy, 0);
    chk("rm_F_clr", F, 0);
    chk("rm_carry_clr", carry, 0);
    rst = 1'b0;
    #1;
    chk("rm_in_ready", in_ready, 1);
    run_op(3'd4, 8'hF0, 8'h3C, 0, f, z, c, lat, nb);
    chk("rm_and_F", f, 16'h0030);
    chk("rm_and_zero", z, 0);
    chk("rm_and_latency", lat, 1);

    // Reset coinciding with an accept: reset wins, nothing is started
    Sel      = 3'd0;
    A        = 8'd1;
    B        = 8'd2;
    in_valid = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    chk("ra_out_valid", out_valid, 0);
    chk("ra_busy", busy, 0);
    chk("ra_in_ready", in_ready, 1);
    @(negedge clk);
    chk("ra_no_result", out_valid, 0);

    // Randomized ops with random consumer stalls
    for (int i = 0; i < 150; i++) begin
      rs = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = 8'($urandom);
      model(rs, ra, rb, ef, ec);
      run_op(rs, ra, rb, $urandom_range(0, 3), f, z, c, lat, nb);
      chk("rnd_F", f, ef);
      chk("rnd_zero", z, (ef == 16'h0000));
      chk("rnd_carry", c, ec);
      chk("rnd_latency", lat, (rs == 3'd2) ? 9 : 1);
      chk("rnd_busy_cycles", nb, (rs == 3'd2) ? 8 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
